// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl: queues completed sales, runs the item motor, then ejects change coins (2 first, then 1); optional COIN_ACK_TIMEOUT_EN bounds the ejector wait
module vend_dispense_ctrl #(
  parameter int DEPTH = 4,
  parameter int MOTOR_CYCLES = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dispense,
  input  logic [2:0] change,
  output logic       motor_on,
  output logic       coin_req,
  output logic       coin_sel,
  input  logic       coin_ack,
  output logic       vend_done,
  output logic       busy,
  output logic       queue_full,
  output logic       overflow,
  output logic       fault
);
  localparam int AW = $clog2(DEPTH);
  localparam int MW = $clog2(MOTOR_CYCLES + 1);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  localparam logic [MW-1:0] MLOAD = MW'(MOTOR_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, MOTOR, COIN_REQ, COIN_GAP, DONE} state_t;
  state_t state, state_n;
  logic [1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [1:0] rem, rem_n;
  logic [MW-1:0] mcnt, mcnt_n;
  logic push, pop, timeout;
  logic motor_n, req_n, sel_n, done_n;
  assign queue_full = count == FULL;
  assign busy = state != IDLE || count != '0;
  assign push = dispense && !queue_full;
  assign pop = state == IDLE && count != '0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= change > 3'd3 ? 2'd3 : change[1:0];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
      overflow <= overflow | (dispense & queue_full);
    end
`ifdef COIN_ACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tcnt;
  assign timeout = state == COIN_REQ && !coin_ack && tcnt == TLAST;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tcnt <= '0;
      fault <= 1'b0;
    end else begin
      tcnt <= state == COIN_REQ ? tcnt + 1'b1 : '0;
      fault <= fault | timeout;
    end
`else
  assign timeout = 1'b0;
  assign fault = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      rem <= '0;
      mcnt <= '0;
      motor_on <= 1'b0;
      coin_req <= 1'b0;
      coin_sel <= 1'b0;
      vend_done <= 1'b0;
    end else begin
      state <= state_n;
      rem <= rem_n;
      mcnt <= mcnt_n;
      motor_on <= motor_n;
      coin_req <= req_n;
      coin_sel <= sel_n;
      vend_done <= done_n;
    end
  always_comb begin
    state_n = state;
    rem_n = rem;
    mcnt_n = mcnt;
    case (state)
      IDLE: if (pop) begin
        state_n = MOTOR;
        rem_n = mem[rd_ptr];
        mcnt_n = MLOAD;
      end
      MOTOR: begin
        state_n = mcnt != '0 ? MOTOR : rem != '0 ? COIN_REQ : DONE;
        mcnt_n = mcnt - 1'b1;
      end
      COIN_REQ: if (coin_ack) begin
        state_n = COIN_GAP;
        rem_n = rem - (rem[1] ? 2'd2 : 2'd1);
      end else if (timeout) begin
        state_n = DONE;
        rem_n = '0;
      end
      COIN_GAP: state_n = rem != '0 ? COIN_REQ : DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    motor_n = state_n == MOTOR;
    req_n = state_n == COIN_REQ;
    sel_n = req_n & rem_n[1];
    done_n = state_n == DONE;
  end
endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// tb_vend_dispense_ctrl: directed and randomized sales checked each cycle against a sale-plan reference model
module tb_vend_dispense_ctrl;
  localparam int DEPTH = 4, MC = 8, TO = 64;
  localparam int P_NONE = -1, P_MOTOR = 0, P_GAP = 1, P_DONE = 2, P_COIN1 = 3, P_COIN2 = 4;
  logic clk = 0, reset = 1, dispense = 0, coin_ack = 0;
  logic [2:0] change = 0;
  logic motor_on, coin_req, coin_sel, vend_done, busy, queue_full, overflow, fault;
  int checks = 0, errors = 0;
  int q[$], plan[$];
  int waited = 0, cur, m_c;
  bit m_ovf = 0, m_fault = 0, m_idle, m_full;
  int req_age = 0, ack_delay = 2, acks_taken = 0;
  bit ack_never = 0, ack_noise = 0;
  int pat[6] = '{1, 2, 3, 0, 1, 2};

  vend_dispense_ctrl #(.DEPTH(DEPTH), .MOTOR_CYCLES(MC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .dispense(dispense), .change(change),
    .motor_on(motor_on), .coin_req(coin_req), .coin_sel(coin_sel), .coin_ack(coin_ack),
    .vend_done(vend_done), .busy(busy), .queue_full(queue_full), .overflow(overflow), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0b expected %0b at %0t", n, a, e, $time);
    end
  endtask

  task automatic chk_int(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference model: each popped sale expands into a plan of per-cycle steps; coin steps last until acked
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      plan.delete();
      waited = 0;
      m_ovf = 0;
      m_fault = 0;
    end else begin
      m_idle = plan.size() == 0;
      m_full = q.size() == DEPTH;
      if (!m_idle) begin
        if (plan[0] >= P_COIN1) begin
          if (coin_ack) begin
            void'(plan.pop_front());
            waited = 0;
          end
`ifdef COIN_ACK_TIMEOUT_EN
          else begin
            waited = waited + 1;
            if (waited == TO) begin
              while (plan[0] != P_DONE) void'(plan.pop_front());
              waited = 0;
              m_fault = 1;
            end
          end
`endif
        end else void'(plan.pop_front());
      end
      if (m_idle && q.size() > 0) begin
        m_c = q.pop_front();
        repeat (MC) plan.push_back(P_MOTOR);
        if (m_c >= 2) begin
          plan.push_back(P_COIN2);
          plan.push_back(P_GAP);
        end
        if (m_c % 2 == 1) begin
          plan.push_back(P_COIN1);
          plan.push_back(P_GAP);
        end
        plan.push_back(P_DONE);
      end
      if (dispense) begin
        if (m_full) m_ovf = 1;
        else q.push_back(change > 3 ? 3 : int'(change));
      end
    end
  end

  always @(negedge clk) if (!reset) begin
    cur = plan.size() > 0 ? plan[0] : P_NONE;
    chk("motor_on", motor_on, cur == P_MOTOR);
    chk("coin_req", coin_req, cur >= P_COIN1);
    chk("coin_sel", coin_sel, cur == P_COIN2);
    chk("vend_done", vend_done, cur == P_DONE);
    chk("busy", busy, plan.size() > 0 || q.size() > 0);
    chk("queue_full", queue_full, q.size() == DEPTH);
    chk("overflow", overflow, m_ovf);
    chk("fault", fault, m_fault);
  end

  always @(negedge clk) begin
    if (coin_req) begin
      req_age++;
      coin_ack = !ack_never && req_age >= ack_delay;
    end else begin
      req_age = 0;
      coin_ack = ack_noise && ($urandom_range(0, 3) == 0);
    end
  end

  always @(posedge clk) if (coin_req && coin_ack) acks_taken++;

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
    end
    chk("drain_bound", busy, 1'b0);
  endtask

  task automatic run_sale(input logic [2:0] ch, output int sels, output int nreq, output int ndone);
    int n = 0;
    logic prev = 0;
    sels = 0;
    nreq = 0;
    ndone = 0;
    dispense = 1;
    change = ch;
    tick();
    dispense = 0;
    while (busy && n < 300) begin
      if (coin_req && !prev) begin
        nreq++;
        sels = sels * 2 + int'(coin_sel);
      end
      prev = coin_req;
      ndone += int'(vend_done);
      tick();
      n++;
    end
    chk("sale_bound", busy, 1'b0);
  endtask

  initial begin
    int first, nm, dc, nreq, sels, ndone, a0;
    bit fs;
    repeat (3) tick();
    chk_int("reset_outputs", {motor_on, coin_req, coin_sel, vend_done, busy, queue_full, overflow, fault}, 0);
    reset = 0;
    tick();
    dispense = 1;
    change = 0;
    first = 0;
    nm = 0;
    dc = 0;
    nreq = 0;
    for (int i = 1; i <= 11; i++) begin
      tick();
      dispense = 0;
      if (motor_on) begin
        nm++;
        if (first == 0) first = i;
      end
      if (vend_done) dc = i;
      nreq += int'(coin_req);
    end
    chk_int("t1_motor_len", nm, 8);
    chk_int("t1_motor_first", first, 2);
    chk_int("t1_done_cycle", dc, 10);
    chk_int("t1_reqs", nreq, 0);
    chk("t1_busy_end", busy, 1'b0);
    a0 = acks_taken;
    run_sale(3'd3, sels, nreq, ndone);
    chk_int("t2_sel_order", sels, 2);
    chk_int("t2_reqs", nreq, 2);
    chk_int("t2_acks", acks_taken - a0, 2);
    chk_int("t2_done", ndone, 1);
    fs = 0;
    for (int i = 0; i < 6; i++) begin
      dispense = 1;
      change = 3'(pat[i]);
      tick();
      fs |= queue_full;
      if (i == 4) chk("t3_no_drop_fifth", overflow, 1'b0);
    end
    dispense = 0;
    chk("t3_overflow", overflow, 1'b1);
    chk("t3_full_seen", fs, 1'b1);
    ndone = 0;
    for (int n = 0; n < 600 && busy; n++) begin
      ndone += int'(vend_done);
      tick();
    end
    chk("t3_drained", busy, 1'b0);
    chk_int("t3_done", ndone, 5);
    run_sale(3'd5, sels, nreq, ndone);
    chk_int("t4_sel_order", sels, 2);
    chk_int("t4_reqs", nreq, 2);
    dispense = 1;
    change = 2;
    tick();
    change = 1;
    tick();
    change = 3;
    tick();
    dispense = 0;
    for (int n = 0; n < 40 && !coin_req; n++) tick();
    chk("t5_reached_req", coin_req, 1'b1);
    @(posedge clk);
    #2 reset = 1;
    #1;
    chk_int("t5_async_zero", {motor_on, coin_req, coin_sel, vend_done, busy, queue_full, overflow, fault}, 0);
    tick();
    tick();
    reset = 0;
    nm = 0;
    repeat (20) begin
      tick();
      nm += int'(motor_on) + int'(coin_req);
    end
    chk_int("t5_quiet", nm, 0);
`ifdef COIN_ACK_TIMEOUT_EN
    ack_never = 1;
    dispense = 1;
    change = 2;
    tick();
    change = 1;
    tick();
    dispense = 0;
    for (int n = 0; n < 40 && !coin_req; n++) tick();
    nm = 0;
    for (int n = 0; n < 200 && coin_req; n++) begin
      nm++;
      tick();
    end
    chk_int("t6_req_len", nm, TO);
    chk("t6_fault", fault, 1'b1);
    chk("t6_done", vend_done, 1'b1);
    ack_never = 0;
    wait_idle();
`endif
    ack_noise = 1;
    for (int n = 0; n < 3000; n++) begin
      dispense = $urandom_range(0, 5) == 0;
      change = 3'($urandom_range(0, 7));
      ack_delay = $urandom_range(1, 4);
      tick();
    end
    dispense = 0;
    ack_noise = 0;
    wait_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vend_dispense_ctrl.md
Name: vend_dispense_ctrl

Overview:
Downstream stage of the 7₹ vending FSM. It consumes that FSM's one-cycle dispense pulse and 3-bit change amount and queues each sale in a small FIFO. For each queued sale it drives the item motor for a fixed time, then ejects change coins (2₹ first, then 1₹) through a req/ack handshake to the coin ejector. The queue lets back-to-back sales be accepted while a previous sale is still being served.

Parameters:
DEPTH, 4, number of pending-sale entries in the queue (power of 2, ≥2)
MOTOR_CYCLES, 8, clock cycles motor_on is held per sale (≥1)
TIMEOUT_CYCLES, 64, max cycles coin_req waits for coin_ack (used only with the optional feature)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
dispense  input  1  one-cycle pulse from vending FSM: a sale has completed
change  input  3  change owed in ₹, sampled only when dispense=1; legal 0..3
motor_on  output  1  item motor drive, registered
coin_req  output  1  coin eject request, registered
coin_sel  output  1  coin to eject: 0=1₹, 1=2₹; stable while coin_req=1
coin_ack  input  1  ejector acknowledge; one coin released
vend_done  output  1  one-cycle pulse when a sale is fully served
busy  output  1  FSM not in IDLE, or queue non-empty
queue_full  output  1  queue holds DEPTH entries
overflow  output  1  sticky: a sale was dropped because the queue was full
fault  output  1  sticky: coin ejector timed out (optional feature)

Behaviour:
- Reset (async, any time, mid-operation included): queue emptied; FSM → IDLE. All outputs 0: motor_on, coin_req, coin_sel, vend_done, busy, queue_full, overflow, fault. Reset mid-vend abandons the sale; no vend_done.
- Push: dispense=1 and queue not full → write entry {change} at that edge. If change>3, the stored value saturates to 3.
- Full check: full uses the registered count. A push while full is dropped and sets overflow, even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full: both happen; count is unchanged.
- FSM states: IDLE, MOTOR, COIN_REQ, COIN_GAP, DONE.
- IDLE: if queue non-empty, pop the head, load remaining change and the motor counter, go to MOTOR.
- MOTOR: motor_on=1 for exactly MOTOR_CYCLES cycles. Then go to COIN_REQ if change≠0, else DONE.
- COIN_REQ: coin_req=1. coin_sel=1 if remaining≥2, else 0. On coin_ack=1 sampled at an edge: remaining −= (coin_sel?2:1), go to COIN_GAP. coin_ack outside COIN_REQ is ignored.
- COIN_GAP: coin_req=0 for exactly one cycle. Then COIN_REQ if remaining≠0, else DONE.
- Change decomposition: 3=2₹+1₹, 2=2₹, 1=1₹.
- DONE: vend_done=1 for one cycle, then IDLE.
- Latency: dispense high in cycle 0 with FSM idle and queue empty → motor_on high in cycles 2..2+MOTOR_CYCLES−1.
- Consecutive sales: DONE→IDLE→MOTOR. At least 1 idle cycle separates motor_on periods.
- queue_full and busy are derived from registered state.
- FIFO pointers wrap modulo DEPTH. The count is log2(DEPTH)+1 bits wide.

Optional Feature:
Macro COIN_ACK_TIMEOUT_EN.
- Defined: a counter runs while in COIN_REQ and clears on entry to COIN_REQ. If TIMEOUT_CYCLES elapse without coin_ack:
  - coin_req drops and fault sets (sticky until reset);
  - the remaining change of this sale is discarded;
  - FSM goes to DONE; vend_done still pulses.
- Not defined: COIN_REQ waits indefinitely; fault tied to 0.

Test Plan:
- Reset, then dispense with change=0 (MOTOR_CYCLES=8) → motor_on high cycles 2..9; vend_done pulse at cycle 10; coin_req never asserts; busy returns to 0.
- Dispense with change=3, ejector acks 2 cycles after each req → first req with coin_sel=1, then one cycle req=0, second req with coin_sel=0, then vend_done. Exactly 2 acks consumed.
- DEPTH=4: five dispense pulses on consecutive cycles (changes 1,2,3,0,1) while the first sale is being served → first four served in order with correct coins; the fifth is dropped only if the queue is full at its cycle; overflow=1 iff a drop occurred; queue_full seen.
- change=5 input → treated as 3 (one 2₹ and one 1₹ coin).
- Async reset asserted during COIN_REQ of a change=2 sale with 2 entries queued → all outputs 0 immediately; after release, no motor_on or coin_req without new dispense.
- With COIN_ACK_TIMEOUT_EN, TIMEOUT_CYCLES=64: change=2, coin_ack never asserted → coin_req drops after 64 cycles; fault=1; vend_done pulses; next queued sale proceeds normally.
